// File: rtl/mips_commit_trace.sv
// mips_commit_trace: passive commit observer for single_cycle_mips, buffering REG/MEM records in a FWFT FIFO
module mips_commit_trace #(
  parameter int PC_W         = 10,
  parameter int DATA_W       = 16,
  parameter int REG_AW       = 4,
  parameter int DEPTH        = 16,
  parameter int STOP_ON_FULL = 0
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       trace_en,
  input  logic                       clear,
  input  logic [PC_W-1:0]            pc,
  input  logic                       reg_write,
  input  logic [REG_AW-1:0]          write_reg,
  input  logic [DATA_W-1:0]          write_back,
  input  logic                       mem_write,
  input  logic [DATA_W-1:0]          mem_addr,
  input  logic [DATA_W-1:0]          mem_wdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [1:0]                 out_kind,
  output logic [7:0]                 out_seq,
  output logic [PC_W-1:0]            out_pc,
  output logic [DATA_W-1:0]          out_dest,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic [7:0]                 drop_count,
  output logic                       overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int RW = 2 + 8 + PC_W + 2 * DATA_W;
  typedef enum logic [1:0] {DISABLED, CAPTURE, HALTED} state_t;
  state_t state;
  logic [RW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [7:0] seq;
  logic [RW-1:0] rec, head;
  logic pop, ev, push, drop;
  assign pop  = (level != '0) && out_ready;
  assign ev   = (state == CAPTURE) && (reg_write || mem_write);
  assign push = ev && (level != LW'(DEPTH) || pop);
  assign drop = ev && !push;
  // A conflicting commit records the store fields; the register write is implied by the kind.
  assign rec = {mem_write, reg_write, seq, pc,
                mem_write ? mem_addr : {{(DATA_W-REG_AW){1'b0}}, write_reg},
                mem_write ? mem_wdata : write_back};
  assign head = mem[rd_ptr];
  assign out_valid = level != '0;
  assign {out_kind, out_seq, out_pc, out_dest, out_data} = out_valid ? head : '0;
  always_ff @(posedge clock) begin
    if (push && reset_n && !clear) mem[wr_ptr] <= rec;
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= DISABLED;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      level      <= '0;
      seq        <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
    end else if (clear) begin
      state      <= trace_en ? CAPTURE : DISABLED;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      level      <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(push) - LW'(pop);
      if (ev) seq <= seq + 8'd1;
      if (drop) begin
        drop_count <= drop_count + 8'(drop_count != 8'hff);
        overflow   <= 1'b1;
      end
      state <= (state == DISABLED && trace_en) ? CAPTURE :
               (state == CAPTURE && drop && STOP_ON_FULL != 0) ? HALTED :
               (state == CAPTURE && !trace_en) ? DISABLED : state;
    end
  end
endmodule

// File: tb/tb_mips_commit_trace.sv
// tb_mips_commit_trace: random and directed checks of two trace buffers (keep-capturing and stop-on-full)
module tb_mips_commit_trace;
  localparam int PC_W = 10, DATA_W = 16, REG_AW = 4, DEPTH = 16;
  logic clock = 0;
  always #5 clock = ~clock;
  logic reset_n = 0, trace_en = 0, clear = 0, reg_write = 0, mem_write = 0, out_ready = 0;
  logic [PC_W-1:0] pc = 0;
  logic [REG_AW-1:0] write_reg = 0;
  logic [DATA_W-1:0] write_back = 0, mem_addr = 0, mem_wdata = 0;
  logic o_valid [2];
  logic [1:0] o_kind [2];
  logic [7:0] o_seq [2];
  logic [PC_W-1:0] o_pc [2];
  logic [DATA_W-1:0] o_dest [2], o_data [2];
  logic [4:0] o_level [2];
  logic [7:0] o_drop [2];
  logic o_ovf [2];
  int n_chk = 0, n_fail = 0;
  // reference model: circular record store per instance, records packed as kind,seq,pc,dest,data
  logic [51:0] mfifo [2][DEPTH];
  int mlvl [2], mhead [2], mseq [2], mdrop [2], mst [2];
  bit movf [2];
  int stop [2] = '{0, 1};

  mips_commit_trace #(.PC_W(PC_W), .DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH), .STOP_ON_FULL(0)) u0 (
    .clock(clock), .reset_n(reset_n), .trace_en(trace_en), .clear(clear), .pc(pc),
    .reg_write(reg_write), .write_reg(write_reg), .write_back(write_back), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .out_valid(o_valid[0]), .out_ready(out_ready),
    .out_kind(o_kind[0]), .out_seq(o_seq[0]), .out_pc(o_pc[0]), .out_dest(o_dest[0]),
    .out_data(o_data[0]), .level(o_level[0]), .drop_count(o_drop[0]), .overflow(o_ovf[0]));
  mips_commit_trace #(.PC_W(PC_W), .DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH), .STOP_ON_FULL(1)) u1 (
    .clock(clock), .reset_n(reset_n), .trace_en(trace_en), .clear(clear), .pc(pc),
    .reg_write(reg_write), .write_reg(write_reg), .write_back(write_back), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .out_valid(o_valid[1]), .out_ready(out_ready),
    .out_kind(o_kind[1]), .out_seq(o_seq[1]), .out_pc(o_pc[1]), .out_dest(o_dest[1]),
    .out_data(o_data[1]), .level(o_level[1]), .drop_count(o_drop[1]), .overflow(o_ovf[1]));

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step(int i);
    bit pop, dropped;
    logic [51:0] r;
    if (!reset_n) begin
      mlvl[i] = 0; mhead[i] = 0; mseq[i] = 0; mdrop[i] = 0; movf[i] = 0; mst[i] = 0;
      return;
    end
    if (clear) begin
      mlvl[i] = 0; mhead[i] = 0; mdrop[i] = 0; movf[i] = 0; mst[i] = trace_en ? 1 : 0;
      return;
    end
    pop = mlvl[i] > 0 && out_ready;
    dropped = 0;
    if (pop) begin
      mhead[i] = (mhead[i] + 1) % DEPTH;
      mlvl[i]--;
    end
    if (mst[i] == 1 && (reg_write || mem_write)) begin
      r = {mem_write, reg_write, 8'(mseq[i]), pc,
           mem_write ? mem_addr : DATA_W'(write_reg), mem_write ? mem_wdata : write_back};
      mseq[i] = (mseq[i] + 1) % 256;
      if (mlvl[i] < DEPTH) begin
        mfifo[i][(mhead[i] + mlvl[i]) % DEPTH] = r;
        mlvl[i]++;
      end else begin
        dropped = 1;
        if (mdrop[i] < 255) mdrop[i]++;
        movf[i] = 1;
      end
    end
    if (mst[i] == 0) mst[i] = trace_en ? 1 : 0;
    else if (mst[i] == 1) mst[i] = (dropped && stop[i] != 0) ? 2 : (trace_en ? 1 : 0);
  endtask

  task automatic check();
    logic [51:0] h;
    for (int i = 0; i < 2; i++) begin
      h = mlvl[i] > 0 ? mfifo[i][mhead[i]] : '0;
      chk($sformatf("u%0d valid", i), 64'(o_valid[i]), 64'(mlvl[i] > 0));
      chk($sformatf("u%0d kind", i), 64'(o_kind[i]), 64'(h[51:50]));
      chk($sformatf("u%0d seq", i), 64'(o_seq[i]), 64'(h[49:42]));
      chk($sformatf("u%0d pc", i), 64'(o_pc[i]), 64'(h[41:32]));
      chk($sformatf("u%0d dest", i), 64'(o_dest[i]), 64'(h[31:16]));
      chk($sformatf("u%0d data", i), 64'(o_data[i]), 64'(h[15:0]));
      chk($sformatf("u%0d level", i), 64'(o_level[i]), 64'(mlvl[i]));
      chk($sformatf("u%0d drop_count", i), 64'(o_drop[i]), 64'(mdrop[i]));
      chk($sformatf("u%0d overflow", i), 64'(o_ovf[i]), 64'(movf[i]));
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    for (int i = 0; i < 2; i++) model_step(i);
    @(negedge clock);
    check();
  endtask

  initial begin
    cyc(); cyc();
    chk("reset valid", 64'(o_valid[0]), 0);
    chk("reset level", 64'(o_level[0]), 0);
    // first REG commit
    reset_n = 1; trace_en = 1; cyc();
    reg_write = 1; write_reg = 3; write_back = 16'h00ab; pc = 5; cyc();
    reg_write = 0;
    chk("t1 valid", 64'(o_valid[0]), 1);
    chk("t1 kind", 64'(o_kind[0]), 1);
    chk("t1 seq", 64'(o_seq[0]), 0);
    chk("t1 dest", 64'(o_dest[0]), 3);
    chk("t1 data", 64'(o_data[0]), 16'h00ab);
    chk("t1 pc", 64'(o_pc[0]), 5);
    // store replaces the popped REG record, then is held
    mem_write = 1; mem_addr = 16'h0010; mem_wdata = 16'hbeef; pc = 6; out_ready = 1; cyc();
    mem_write = 0; out_ready = 0;
    chk("t2 kind", 64'(o_kind[0]), 2);
    chk("t2 seq", 64'(o_seq[0]), 1);
    chk("t2 level", 64'(o_level[0]), 1);
    cyc(); cyc();
    chk("t2 hold kind", 64'(o_kind[0]), 2);
    chk("t2 hold dest", 64'(o_dest[0]), 16'h0010);
    chk("t2 hold data", 64'(o_data[0]), 16'hbeef);
    out_ready = 1; cyc(); out_ready = 0;
    chk("t2 pop level", 64'(o_level[0]), 0);
    chk("t2 pop valid", 64'(o_valid[0]), 0);
    chk("t2 pop data", 64'(o_data[0]), 0);
    // overfill with 18 commits
    reset_n = 0; cyc(); reset_n = 1; cyc();
    for (int k = 0; k < 18; k++) begin
      reg_write = 1; write_reg = 4'(k); write_back = 16'(k); pc = 10'(k); cyc();
    end
    reg_write = 0;
    chk("t3 level", 64'(o_level[0]), 16);
    chk("t3 drops", 64'(o_drop[0]), 2);
    chk("t3 overflow", 64'(o_ovf[0]), 1);
    chk("t3 head seq", 64'(o_seq[0]), 0);
    chk("t3 stop drops", 64'(o_drop[1]), 1);
    // push and pop at full
    reg_write = 1; write_back = 16'h0055; out_ready = 1; cyc(); reg_write = 0;
    chk("t4 level", 64'(o_level[0]), 16);
    chk("t4 drops", 64'(o_drop[0]), 2);
    chk("t4 head seq", 64'(o_seq[0]), 1);
    chk("t4 stop level", 64'(o_level[1]), 15);
    for (int k = 0; k < 14; k++) cyc();
    chk("t3 last stored seq", 64'(o_seq[0]), 15);
    cyc();
    chk("t4 pushed seq", 64'(o_seq[0]), 18);
    chk("t4 pushed data", 64'(o_data[0]), 16'h0055);
    cyc();
    chk("t4 drained", 64'(o_level[0]), 0);
    chk("t4 stop drained", 64'(o_level[1]), 0);
    // halted instance ignores commits until clear
    reg_write = 1; cyc();
    chk("t5 halted level", 64'(o_level[1]), 0);
    clear = 1; cyc(); clear = 0;
    chk("t5 clr level", 64'(o_level[1]), 0);
    chk("t5 clr drops", 64'(o_drop[1]), 0);
    chk("t5 clr overflow", 64'(o_ovf[1]), 0);
    chk("t5 clr drops u0", 64'(o_drop[0]), 0);
    write_reg = 9; out_ready = 0; cyc(); reg_write = 0;
    chk("t5 capture valid", 64'(o_valid[1]), 1);
    chk("t5 frozen seq", 64'(o_seq[1]), 17);
    // conflict record, then reset mid-drain
    reg_write = 1; mem_write = 1; write_reg = 7; write_back = 16'h1111;
    mem_addr = 16'h2222; mem_wdata = 16'h3333; pc = 9; out_ready = 1; cyc();
    chk("t6 kind", 64'(o_kind[0]), 3);
    chk("t6 dest", 64'(o_dest[0]), 16'h2222);
    chk("t6 data", 64'(o_data[0]), 16'h3333);
    chk("t6 pc", 64'(o_pc[0]), 9);
    out_ready = 0; cyc();
    reset_n = 0; out_ready = 1; reg_write = 0; mem_write = 0; cyc();
    chk("t6 rst valid", 64'(o_valid[0]), 0);
    chk("t6 rst level", 64'(o_level[0]), 0);
    chk("t6 rst kind", 64'(o_kind[0]), 0);
    reset_n = 1;
    for (int k = 0; k < 3000; k++) begin
      reset_n = $urandom_range(0, 299) != 0;
      clear = $urandom_range(0, 99) == 0;
      trace_en = $urandom_range(0, 19) != 0;
      reg_write = 1'($urandom); mem_write = 1'($urandom);
      out_ready = ((k / 200) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      pc = 10'($urandom); write_reg = 4'($urandom); write_back = 16'($urandom);
      mem_addr = 16'($urandom); mem_wdata = 16'($urandom);
      cyc();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
